phasetofreq: RTL



---
 rtl/phasetofreq_pkg.sv | 19 +
 rtl/phasetofreq_if.sv | 16 +
 rtl/phasetofreq_period_counter.sv | 38 +++
 rtl/phasetofreq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/phasetofreq_pkg.sv
// rtl/phasetofreq_pkg.sv - shared widths, timeout limit and FSM state type for phasetofreq
package phasetofreq_pkg;

    localparam int PHASE_W = 8;
    localparam int FREQ_W  = 13;
    localparam int CNT_W   = FREQ_W + 1;

    // No step for this many cycles means the generator has stopped or frozen.
    localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'((1 << FREQ_W) + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = TIMEOUT - CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2,
        STOP = 2'd3
    } state_t;

endpackage

// File: rtl/phasetofreq_if.sv
// rtl/phasetofreq_if.sv - phase bus in, recovered freq/lock/status out
interface phasetofreq_if;
    import phasetofreq_pkg::*;

    logic [PHASE_W-1:0] phase;
    logic [FREQ_W-1:0]  freq;
    logic               locked;
    logic               upd;
    logic               err;

    // Master drives the phase bus and observes the decode.
    modport master (output phase, input freq, input locked, input upd, input err);
    // Slave is the recovery block itself.
    modport slave  (input phase, output freq, output locked, output upd, output err);

endinterface

// File: rtl/phasetofreq_period_counter.sv
// rtl/phasetofreq_period_counter.sv - cycles since last phase step, saturating, with timeout pulse
module phasetofreq_period_counter
    import phasetofreq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             restart_i,
    output logic [CNT_W-1:0] count_o,
    output logic             timeout_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Restart at 1 so the value seen on the next step equals the step-to-step period.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != TIMEOUT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o   = cnt_q;
    // Fires once, on the cycle the count would saturate; a step that same cycle wins.
    assign timeout_o = !restart_i && (cnt_q == TIMEOUT_M1);

endmodule

// File: rtl/phasetofreq.sv
// rtl/phasetofreq.sv - recovers the freq word driving a phase counter stream
module phasetofreq
    import phasetofreq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    phasetofreq_if.slave bus
);

    logic [PHASE_W-1:0] phase_q;
    logic               step_q;
    logic               good_q;
    logic               zero_q;
    logic               step_d;
    logic               good_d;
    logic               zero_d;

    logic [CNT_W-1:0]   n_cnt;
    logic               timeout;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cand_q;
    logic [CNT_W-1:0]   cand_d;
    logic [FREQ_W-1:0]  freq_q;
    logic [FREQ_W-1:0]  freq_d;
    logic               locked_q;
    logic               locked_d;
    logic               upd_q;
    logic               upd_d;
    logic               err_q;
    logic               err_d;

    assign step_d = (bus.phase != phase_q);
    assign good_d = (bus.phase == phase_q + PHASE_W'(1));
    assign zero_d = (bus.phase == '0);

    // Input stage: sample phase and classify the change against the previous sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            step_q  <= 1'b0;
            good_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            phase_q <= bus.phase;
            step_q  <= step_d;
            good_q  <= good_d;
            zero_q  <= zero_d;
        end
    end

    phasetofreq_period_counter u_period_counter (
        .clk       (clk),
        .rst       (rst),
        .restart_i (step_q),
        .count_o   (n_cnt),
        .timeout_o (timeout)
    );

    // Decode FSM: a step outranks a coincident timeout; any change of freq/locked raises upd.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        freq_d   = freq_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        if (step_q) begin
            if (!good_q) begin
                // A jump to zero is a generator restart, not a fault.
                state_d  = IDLE;
                locked_d = 1'b0;
                err_d    = !zero_q;
            end else if (state_q != IDLE && n_cnt == CNT_W'(1)) begin
                // Stepping every clock cannot come from the generator.
                state_d  = IDLE;
                locked_d = 1'b0;
                err_d    = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = ACQ;
                        cand_d  = '0;
                    end
                    ACQ: begin
                        if (n_cnt == cand_q) begin
                            state_d  = LOCK;
                            freq_d   = FREQ_W'(n_cnt - CNT_W'(1));
                            locked_d = 1'b1;
                        end else begin
                            cand_d = n_cnt;
                        end
                    end
                    LOCK: begin
                        if (n_cnt != {1'b0, freq_q} + CNT_W'(1)) begin
                            state_d  = ACQ;
                            cand_d   = n_cnt;
                            locked_d = 1'b0;
                        end
                    end
                    STOP: begin
                        state_d  = ACQ;
                        cand_d   = '0;
                        locked_d = 1'b0;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end else if (timeout && state_q != STOP) begin
            if (phase_q == '0) begin
                state_d  = STOP;
                freq_d   = '0;
                locked_d = 1'b1;
            end else begin
                state_d  = IDLE;
                locked_d = 1'b0;
                err_d    = 1'b1;
            end
        end
        upd_d = (freq_d != freq_q) || (locked_d != locked_q);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            freq_q   <= '0;
            locked_q <= 1'b0;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            freq_q   <= freq_d;
            locked_q <= locked_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
        end
    end

    assign bus.freq   = freq_q;
    assign bus.locked = locked_q;
    assign bus.upd    = upd_q;
    assign bus.err    = err_q;

endmodule
